// File: rtl/wait_state_memory.sv
// Single-port synchronous data memory with valid/ready requests and WAIT_CYCLES wait states.
// Optional `define MEM_PRELOAD_EN seeds words 500..509 with 1..10 at time 0.
module wait_state_memory #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 10,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef logic [DEPTH-1:0][DATA_WIDTH-1:0] image_t;

  function automatic image_t init_image();
    image_t img;
    img = '0;
`ifdef MEM_PRELOAD_EN
    for (int i = 0; i < 10; i++) begin
      if (500 + i < DEPTH) img[500 + i] = DATA_WIDTH'(i + 1);
    end
`endif
    return img;
  endfunction

  localparam image_t MEM_INIT = init_image();

  // Power-up image is part of the array declaration; reset never touches it.
  image_t mem = MEM_INIT;

  state_t                state;
  logic [3:0]            cnt;
  logic                  lat_write;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;

  logic                  accept;
  logic                  commit;
  logic                  c_write;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic                  c_in_range;
  logic [IDX_W-1:0]      c_idx;

  // Ready is gated by rst so a request presented alongside reset is never taken.
  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // With zero wait states the commit happens on the acceptance edge itself,
  // so the commit operands come straight from the request ports.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    c_write = lat_write;
    c_addr  = lat_addr;
    c_wdata = lat_wdata;
    commit  = 1'b0;
    if (state == IDLE) begin
      c_write = req_write;
      c_addr  = req_addr;
      c_wdata = req_wdata;
      commit  = accept && (WAIT_CYCLES == 0);
    end else if (state == WAIT) begin
      commit  = !rst && (cnt == 4'd0);
    end
    c_in_range = ({1'b0, c_addr} < DEPTH_W);
    c_idx      = c_addr[IDX_W-1:0];
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            cnt       <= CNT_LOAD;
            state     <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (commit) begin
        resp_valid <= 1'b1;
        resp_err   <= !c_in_range;
        if (c_write)         resp_rdata <= c_wdata;
        else if (c_in_range) resp_rdata <= mem[c_idx];
        else                 resp_rdata <= '0;
      end
    end
  end

  // NOTE: the storage array has no reset; clearing it would need a per-word reset network.
  always_ff @(posedge clk) begin
    if (commit && c_write && c_in_range) mem[c_idx] <= c_wdata;
  end

endmodule

// File: tb/tb_wait_state_memory.sv
// Self-checking bench: a 600-word/2-wait instance and a 1024-word/0-wait instance
// checked against a word-array reference model.
module tb_wait_state_memory;

  localparam int DW      = 16;
  localparam int AW      = 10;
  localparam int DEPTH_A = 600;
  localparam int WAIT_A  = 2;
  localparam int DEPTH_B = 1024;
  localparam int WAIT_B  = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          a_valid = 1'b0, a_ready, a_write = 1'b0, a_rvalid, a_err;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0, a_rdata;
  logic          b_valid = 1'b0, b_ready, b_write = 1'b0, b_rvalid, b_err;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0, b_rdata;

  wait_state_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH_A), .WAIT_CYCLES(WAIT_A)) u_dut_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
    .req_addr(a_addr), .req_wdata(a_wdata), .resp_valid(a_rvalid), .resp_rdata(a_rdata), .resp_err(a_err));

  wait_state_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH_B), .WAIT_CYCLES(WAIT_B)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
    .req_addr(b_addr), .req_wdata(b_wdata), .resp_valid(b_rvalid), .resp_rdata(b_rdata), .resp_err(b_err));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain word arrays, one per instance.
  logic [DW-1:0] ma [1024];
  logic [DW-1:0] mb [1024];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic w,
                       input logic [AW-1:0] ad, input logic [DW-1:0] d);
    if (sel == 0) begin a_valid = v; a_write = w; a_addr = ad; a_wdata = d; end
    else          begin b_valid = v; b_write = w; b_addr = ad; b_wdata = d; end
  endtask

  function automatic logic get_ready(input int sel);  return sel == 0 ? a_ready  : b_ready;  endfunction
  function automatic logic get_valid(input int sel);  return sel == 0 ? a_rvalid : b_rvalid; endfunction
  function automatic logic get_err(input int sel);    return sel == 0 ? a_err    : b_err;    endfunction
  function automatic logic [DW-1:0] get_rdata(input int sel); return sel == 0 ? a_rdata : b_rdata; endfunction

  // Applies one request to the model and returns the response it must produce.
  task automatic model(input int sel, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] d,
                       output logic [DW-1:0] erd, output logic eerr);
    int depth;
    depth = (sel == 0) ? DEPTH_A : DEPTH_B;
    if (int'(ad) >= depth) begin
      eerr = 1'b1;
      erd  = w ? d : '0;
    end else begin
      eerr = 1'b0;
      if (w) begin
        erd = d;
        if (sel == 0) ma[ad] = d; else mb[ad] = d;
      end else begin
        erd = (sel == 0) ? ma[ad] : mb[ad];
      end
    end
  endtask

  // One complete transaction; garbage is held on the request port while busy.
  task automatic txn(input int sel, input logic w, input logic [AW-1:0] ad,
                     input logic [DW-1:0] d, input string tag);
    int wc, lat;
    logic [DW-1:0] erd;
    logic eerr;
    wc = (sel == 0) ? WAIT_A : WAIT_B;
    @(negedge clk);
    check({tag, "_ready"}, 32'(get_ready(sel)), 32'd1);
    drive(sel, 1'b1, w, ad, d);
    @(negedge clk);
    drive(sel, 1'b1, ~w, AW'($urandom), DW'($urandom));
    lat = 1;
    while (!get_valid(sel) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(wc + 1));
    model(sel, w, ad, d, erd, eerr);
    check({tag, "_rdata"}, 32'(get_rdata(sel)), 32'(erd));
    check({tag, "_err"}, 32'(get_err(sel)), 32'(eerr));
    check({tag, "_busy"}, 32'(get_ready(sel)), 32'd0);
    drive(sel, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(get_valid(sel)), 32'd0);
    check({tag, "_hold"}, 32'(get_rdata(sel)), 32'(erd));
  endtask

  initial begin
    logic [DW-1:0] erd, d;
    logic eerr;
    logic [AW-1:0] ad, bl [6];
    int lat;

    for (int i = 0; i < 1024; i++) begin ma[i] = '0; mb[i] = '0; end
`ifdef MEM_PRELOAD_EN
    for (int i = 0; i < 10; i++) begin ma[500 + i] = DW'(i + 1); mb[500 + i] = DW'(i + 1); end
`endif

    // Reset held for two cycles
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready_a", 32'(a_ready), 32'd0);
    check("rst_ready_b", 32'(b_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(a_ready), 32'd1);
    check("post_rst_valid", 32'(a_rvalid), 32'd0);
    check("post_rst_rdata", 32'(a_rdata), 32'd0);
    check("post_rst_err", 32'(a_err), 32'd0);

    // Write / read back, preload, out-of-range
    txn(0, 1'b1, 10'd10, 16'hBEEF, "wr10");
    txn(0, 1'b0, 10'd10, 16'h0, "rd10");
    txn(0, 1'b0, 10'd500, 16'h0, "rd500");
    txn(0, 1'b0, 10'd509, 16'h0, "rd509");
    txn(0, 1'b1, 10'd700, 16'd5, "wr700");
    txn(0, 1'b0, 10'd700, 16'h0, "rd700");
    txn(0, 1'b0, 10'd599, 16'h0, "rd599");
    txn(0, 1'b0, 10'd600, 16'h0, "rd600");

    // Reset in first WAIT cycle (addr 3) and on the commit edge (addr 4)
    for (int j = 1; j <= 2; j++) begin
      @(negedge clk);
      drive(0, 1'b1, 1'b1, AW'(2 + j), 16'd7);
      @(negedge clk);
      drive(0, 1'b0, 1'b0, '0, '0);
      repeat (j - 1) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      lat = 0;
      for (int k = 0; k < 5; k++) begin
        if (a_rvalid) lat++;
        @(negedge clk);
      end
      check("abort_no_resp", 32'(lat), 32'd0);
      check("abort_rdata_clr", 32'(a_rdata), 32'd0);
      txn(0, 1'b0, AW'(2 + j), 16'h0, "abort_rd");
    end

    // Reset while in RESP: response drops, write already committed
    d = DW'($urandom);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 10'd42, d);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0, '0);
    lat = 1;
    while (!a_rvalid && lat < 20) begin @(negedge clk); lat++; end
    check("resp_rst_latency", 32'(lat), 32'(WAIT_A + 1));
    model(0, 1'b1, 10'd42, d, erd, eerr);
    rst = 1'b1;
    @(negedge clk);
    check("resp_rst_valid", 32'(a_rvalid), 32'd0);
    check("resp_rst_ready", 32'(a_ready), 32'd0);
    rst = 1'b0;
    txn(0, 1'b0, 10'd42, 16'h0, "resp_rst_rd");

    // Request coincident with reset is not accepted
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b1, 1'b1, 10'd50, 16'h1234);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("rst_req_ignored", 32'(a_ready), 32'd1);
    txn(0, 1'b0, 10'd50, 16'h0, "rst_req_rd");

    // Randomized traffic on both instances
    for (int i = 0; i < 40; i++) begin
      ad = ($urandom_range(0, 2) == 0) ? AW'($urandom_range(590, 620)) : AW'($urandom_range(0, 15));
      txn(0, 1'($urandom), ad, DW'($urandom), "rand_a");
    end
    for (int i = 0; i < 6; i++) begin
      bl[i] = AW'($urandom_range(0, 7));
      txn(1, 1'b1, bl[i], DW'($urandom), "seed_b");
    end
    txn(1, 1'b0, 10'd1023, 16'h0, "rd1023_b");

    // Zero wait states, req_valid held for six back-to-back reads
    @(negedge clk);
    drive(1, 1'b1, 1'b0, bl[0], '0);
    for (int k = 0; k < 6; k++) begin
      check("b2b_ready_hi", 32'(b_ready), 32'd1);
      check("b2b_valid_lo", 32'(b_rvalid), 32'd0);
      @(negedge clk);
      check("b2b_ready_lo", 32'(b_ready), 32'd0);
      check("b2b_valid_hi", 32'(b_rvalid), 32'd1);
      model(1, 1'b0, bl[k], '0, erd, eerr);
      check("b2b_rdata", 32'(b_rdata), 32'(erd));
      if (k < 5) drive(1, 1'b1, 1'b0, bl[k + 1], '0);
      else       drive(1, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
    end
    check("b2b_end_valid", 32'(b_rvalid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wait_state_memory.md
# wait_state_memory

Parametrised single-port data memory with a valid/ready request interface and a configurable number of wait states. It is the next-generation data memory for the multicycle datapath. It replaces the fixed 1024x16, async-read, negedge-write array with a fully synchronous posedge design. The controller FSM issues one request and waits for a one-cycle response pulse carrying read data or a write acknowledge.

## Interface
- DATA_WIDTH, 16, word width in bits
- ADDR_WIDTH, 10, address width in bits
- DEPTH, 1024, number of implemented words; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH
- WAIT_CYCLES, 2, wait states between request acceptance and response; legal range 0..15

- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous active-high reset, sampled on the rising edge of clk
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request this cycle
- req_write  input  1  1 = write, 0 = read; sampled on acceptance
- req_addr  input  ADDR_WIDTH  word address; sampled on acceptance
- req_wdata  input  DATA_WIDTH  write data; sampled on acceptance
- resp_valid  output  1  one-cycle response pulse
- resp_rdata  output  DATA_WIDTH  read data (reads) or echoed write data (writes); valid while resp_valid=1
- resp_err  output  1  address >= DEPTH; valid while resp_valid=1

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid=1, the request is accepted.
  - The block latches req_write, req_addr and req_wdata.
  - It goes to WAIT, or to RESP directly when WAIT_CYCLES=0.
  - The wait counter loads WAIT_CYCLES-1.
- WAIT: req_ready=0. The counter decrements each cycle. At count 0 the FSM moves to RESP.
- Commit edge: the edge that enters RESP.
  - Read: mem[addr] is captured into resp_rdata.
  - Write: mem[addr] <= wdata, and resp_rdata <= wdata.
- RESP: resp_valid=1 for exactly one cycle, req_ready=0, then IDLE. No response backpressure exists; the requester must take the pulse.
- Out of range (latched addr >= DEPTH):
  - Writes are dropped and the array is unchanged.
  - Reads return 0.
  - resp_err=1 with the response. Otherwise resp_err=0.
- Inputs are ignored outside IDLE. req_valid held high during WAIT or RESP is not a new request.
- Array contents are zero at time 0. Reset does not clear the array.

## Timing
- Reset values: req_ready=0 during the reset cycle and 1 from the first cycle after; resp_valid=0, resp_rdata=0, resp_err=0; FSM=IDLE; counter=0.
- Latency: resp_valid rises WAIT_CYCLES+1 cycles after the acceptance edge.
- Throughput: one request per WAIT_CYCLES+2 cycles. req_ready returns high in the cycle after RESP.
- resp_rdata and resp_err hold their last values after resp_valid falls, until the next commit or reset.
- Reset mid-operation (in WAIT): the pending request is aborted with no response. A pending write is not committed.
- Reset on the commit edge: reset wins. There is no commit and no response.
- Reset in RESP: resp_valid drops the following cycle. The already-committed write remains.
- req_valid and rst high in the same cycle: reset wins and the request is not accepted.

## Configuration
- MEM_PRELOAD_EN
  - Defined: at time 0, mem[500+i] = i+1 for i = 0..9, and all other words are 0. Each preload entry applies only if its index is < DEPTH.
  - Undefined: all words are 0 at time 0.
  - Synthesised logic and protocol are identical either way.

## Test plan
- Reset, then idle: after rst is held 2 cycles -> resp_valid=0, resp_rdata=0, req_ready=1 on the first post-reset cycle.
- Write then read, WAIT_CYCLES=2: write addr 10, data 16'hBEEF accepted at edge N.
  - resp_valid=1 in cycle N+3 with resp_rdata=BEEF and resp_err=0.
  - A subsequent read of addr 10 returns BEEF with the same latency.
- Preload, MEM_PRELOAD_EN defined: reads of addr 500 and addr 509 -> 1 and 10. With the macro undefined -> 0 and 0.
- Out of range, DEPTH=600: write addr 700, data 5 -> resp_err=1. A read of addr 700 -> resp_rdata=0 and resp_err=1.
- Abort: write addr 3, data 7, then pulse rst during WAIT -> no resp_valid. A later read of addr 3 returns 0.
- WAIT_CYCLES=0 back-to-back: hold req_valid high for 6 reads -> resp_valid every 2nd cycle, and req_ready toggles 1,0,1,0...
